mem_read_arb: RTL

MEM_READ_ARB -- requirements
Module: mem_read_arb

---
 rtl/mem_read_arb_pkg.sv | 12 +
 rtl/mem_tag_pipe.sv | 48 ++++
 rtl/mem_read_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_read_arb_pkg.sv
// rtl/mem_read_arb_pkg.sv - requester ids and datapath widths shared by mem_read_arb
package mem_read_arb_pkg;

  // Requester ids carried in the tag pipe
  localparam logic FETCH = 1'b0;
  localparam logic LOAD  = 1'b1;

  // Doubleword address [63:3] and read data widths
  localparam int ADDR_W = 61;
  localparam int DATA_W = 64;

endpackage

// File: rtl/mem_tag_pipe.sv
// rtl/mem_tag_pipe.sv - fixed-depth {valid,id} tag pipe tracking reads in flight to memory
module mem_tag_pipe
  import mem_read_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_id,
  input  logic i_flush_fetch,
  output logic o_exit_valid,
  output logic o_exit_id,
  output logic o_any_valid
);

  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_id;
  logic [LATENCY-1:0] w_live;

  // A fetch tag is dead the moment a flush is seen, including the stage exiting now
  always_comb begin
    w_live = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_live[i] = r_valid[i] & ~(i_flush_fetch & (r_id[i] == FETCH));
    end
  end

  // Shift surviving tags one stage per cycle; an empty cycle inserts an invalid tag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_id    <= '0;
    end else begin
      r_valid[0] <= i_push & ~(i_flush_fetch & (i_id == FETCH));
      r_id[0]    <= i_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= w_live[i-1];
        r_id[i]    <= r_id[i-1];
      end
    end
  end

  assign o_exit_valid = w_live[LATENCY-1];
  assign o_exit_id    = r_id[LATENCY-1];
  assign o_any_valid  = |w_live;

endmodule

// File: rtl/mem_read_arb.sv
// rtl/mem_read_arb.sv - fetch/load read arbiter on one memory read port; MEM_READ_ARB_RR_EN selects round-robin
module mem_read_arb
  import mem_read_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetchReqValid,
  input  logic [ADDR_W-1:0] fetchReqAddr,
  output logic              fetchReqReady,
  input  logic              fetchFlush,
  output logic              fetchRspValid,
  output logic [DATA_W-1:0] fetchRspData,
  input  logic              loadReqValid,
  input  logic [ADDR_W-1:0] loadReqAddr,
  output logic              loadReqReady,
  output logic              loadRspValid,
  output logic [DATA_W-1:0] loadRspData,
  output logic              memReadEn,
  output logic [ADDR_W-1:0] memReadAddr,
  input  logic [DATA_W-1:0] memReadData,
  output logic              idle
);

  logic              w_fetch_req;
  logic              w_load_req;
  logic              w_grant_fetch;
  logic              w_grant_load;
  logic              w_exit_valid;
  logic              w_exit_id;
  logic              w_any_valid;
  logic              r_fetch_rsp_valid;
  logic              r_load_rsp_valid;
  logic [DATA_W-1:0] r_fetch_rsp_data;
  logic [DATA_W-1:0] r_load_rsp_data;

  // A flushing fetch never competes; nothing competes while in reset
  assign w_fetch_req = fetchReqValid & ~fetchFlush & ~rst;
  assign w_load_req  = loadReqValid & ~rst;

`ifdef MEM_READ_ARB_RR_EN
  logic r_rr_ptr;

  // Contention goes to the requester named by the pointer; a lone requester always wins
  always_comb begin
    w_grant_fetch = 1'b0;
    w_grant_load  = 1'b0;
    if (w_fetch_req && w_load_req) begin
      w_grant_load  = (r_rr_ptr == LOAD);
      w_grant_fetch = (r_rr_ptr == FETCH);
    end else begin
      w_grant_fetch = w_fetch_req;
      w_grant_load  = w_load_req;
    end
  end

  // Pointer prefers the requester that was not just served; holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= FETCH;
    end else if (w_grant_fetch) begin
      r_rr_ptr <= LOAD;
    end else if (w_grant_load) begin
      r_rr_ptr <= FETCH;
    end
  end
`else
  // Fixed priority: load beats fetch
  always_comb begin
    w_grant_load  = w_load_req;
    w_grant_fetch = w_fetch_req & ~w_load_req;
  end
`endif

  // Memory port and readies follow the grant directly
  always_comb begin
    memReadEn     = w_grant_fetch | w_grant_load;
    fetchReqReady = w_grant_fetch;
    loadReqReady  = w_grant_load;
    memReadAddr   = '0;
    if (w_grant_load) begin
      memReadAddr = loadReqAddr;
    end else if (w_grant_fetch) begin
      memReadAddr = fetchReqAddr;
    end
  end

  mem_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk           (clk),
    .rst           (rst),
    .i_push        (memReadEn),
    .i_id          (w_grant_load ? LOAD : FETCH),
    .i_flush_fetch (fetchFlush),
    .o_exit_valid  (w_exit_valid),
    .o_exit_id     (w_exit_id),
    .o_any_valid   (w_any_valid)
  );

  // Capture returning data for the tag's owner; valid pulses one cycle, data holds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_rsp_valid <= 1'b0;
      r_load_rsp_valid  <= 1'b0;
      r_fetch_rsp_data  <= '0;
      r_load_rsp_data   <= '0;
    end else begin
      r_fetch_rsp_valid <= w_exit_valid && (w_exit_id == FETCH);
      r_load_rsp_valid  <= w_exit_valid && (w_exit_id == LOAD);
      if (w_exit_valid && (w_exit_id == FETCH)) begin
        r_fetch_rsp_data <= memReadData;
      end
      if (w_exit_valid && (w_exit_id == LOAD)) begin
        r_load_rsp_data <= memReadData;
      end
    end
  end

  // Outputs read as reset values for the whole time rst is high
  assign fetchRspValid = r_fetch_rsp_valid & ~rst;
  assign loadRspValid  = r_load_rsp_valid & ~rst;
  assign fetchRspData  = rst ? '0 : r_fetch_rsp_data;
  assign loadRspData   = rst ? '0 : r_load_rsp_data;
  assign idle          = rst | ~(w_any_valid | r_fetch_rsp_valid | r_load_rsp_valid);

endmodule
